uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
//   Each bit is sampled five times around its centre and decided by majority
//   vote. Start bits that vote high are rejected as glitches. The receiver
//   reports parity errors, framing errors and break frames. It returns to IDLE
//   at the decision point of the last stop bit, so a following start edge is
//   never missed.
// Ports:
//   clk        - system clock (only clock)
//   rst        - synchronous active-high reset
//   rxd        - asynchronous serial input, idle high
//   dout       - received word, LSB is the first data bit on the line
//   dout_vld   - one-cycle pulse; dout and the error flags are valid with it
//   parity_err - parity mismatch (qualified by dout_vld)
//   frame_err  - a stop bit was sampled as 0 (qualified by dout_vld)
//   break_det  - all-zero frame with a low stop bit (qualified by dout_vld)
//   busy       - receiver FSM is not idle
module uart_rx_param #(
  parameter int CLK_DIV   = 2604,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CW   = $clog2(CLK_DIV);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int STEP = CLK_DIV / 16;
  localparam int MID  = CLK_DIV / 2;
  localparam int DEC  = MID + 2 * STEP + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(DEC);
  localparam logic [CW-1:0] CNT_BRK  = CW'(MID - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BRK_WAIT
  } state_t;

  state_t               state_reg;
  logic                 s0_reg, s1_reg, s2_reg;
  logic [CW-1:0]        cnt_reg;
  logic [BW-1:0]        bit_idx_reg;
  logic                 stop_idx_reg;
  logic                 stop0_bad_reg;
  logic                 par_bit_reg;
  logic [4:0]           samp_reg;
  logic [DATA_BITS-1:0] shreg_reg;
  logic [DATA_BITS-1:0] dout_reg;
  logic                 dout_vld_reg, parity_err_reg, frame_err_reg, break_det_reg;
  logic                 busy_reg;

  logic [4:0] hit;
  logic       bit_val;
  logic       fall;
  logic       exp_par;
  logic       is_brk;

  // Five sample points, STEP apart, centred on the middle of the bit.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_pt
      localparam int PT = MID + (gi - 2) * STEP;
      assign hit[gi] = (cnt_reg == CW'(PT));
    end
  endgenerate

  // By the decision point samp_reg holds exactly the five samples of this bit.
  assign bit_val = ($countones(samp_reg) >= 3);
  assign fall    = s2_reg & ~s1_reg;
  assign exp_par = (PARITY == 2) ? ^shreg_reg : ~^shreg_reg;
  assign is_brk  = (shreg_reg == '0) && ((PARITY == 0) || !par_bit_reg) && !bit_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      s0_reg         <= 1'b1;
      s1_reg         <= 1'b1;
      s2_reg         <= 1'b1;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      stop_idx_reg   <= 1'b0;
      stop0_bad_reg  <= 1'b0;
      par_bit_reg    <= 1'b0;
      samp_reg       <= '0;
      shreg_reg      <= '0;
      dout_reg       <= '0;
      dout_vld_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      break_det_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      s0_reg <= rxd;
      s1_reg <= s0_reg;
      s2_reg <= s1_reg;

      dout_vld_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      break_det_reg  <= 1'b0;

      if (|hit) samp_reg <= {samp_reg[3:0], s1_reg};

      if (cnt_reg == CNT_LAST) cnt_reg <= '0;
      else                     cnt_reg <= cnt_reg + 1'b1;

      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (fall) begin
            state_reg <= ST_START;
            busy_reg  <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt_reg == CNT_DEC && bit_val) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg   <= ST_DATA;
            bit_idx_reg <= '0;
          end
        end

        ST_DATA: begin
          if (cnt_reg == CNT_DEC) begin
            shreg_reg   <= {bit_val, shreg_reg[DATA_BITS-1:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
          end else if (cnt_reg == CNT_LAST && bit_idx_reg == BIT_LAST) begin
            state_reg     <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            stop_idx_reg  <= 1'b0;
            stop0_bad_reg <= 1'b0;
          end
        end

        ST_PARITY: begin
          if (cnt_reg == CNT_DEC)       par_bit_reg <= bit_val;
          else if (cnt_reg == CNT_LAST) state_reg   <= ST_STOP;
        end

        ST_STOP: begin
          if (cnt_reg == CNT_DEC) begin
            if (STOP_BITS == 2 && !stop_idx_reg) begin
              stop_idx_reg  <= 1'b1;
              stop0_bad_reg <= ~bit_val;
            end else begin
              // Last stop bit decided: report now, skip the rest of the bit.
              dout_reg       <= is_brk ? '0 : shreg_reg;
              dout_vld_reg   <= 1'b1;
              parity_err_reg <= (PARITY != 0) && (par_bit_reg != exp_par);
              frame_err_reg  <= stop0_bad_reg | ~bit_val;
              break_det_reg  <= is_brk;
              if (is_brk) begin
                state_reg <= ST_BRK_WAIT;
                cnt_reg   <= '0;
              end else begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end
            end
          end
        end

        ST_BRK_WAIT: begin
          // cnt counts consecutive high cycles; edges are ignored here.
          if (!s1_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_BRK) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_reg;
  assign dout_vld   = dout_vld_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign break_det  = break_det_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param.
//   Three receivers share one serial line: 8N1 (dut_a), 8E1 (dut_p) and 7O2 (dut_s),
//   all at 32 clocks per bit. Each phase resets the receivers and checks only the
//   one whose frame format is being driven. The expected reports come from a
//   table of hand-derived frames and from a frame-level rule model.
module tb_uart_rx_param;

  localparam int CD = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] dout_a, dout_p;
  logic [6:0] dout_s;
  logic dv_a, pe_a, fe_a, bk_a, busy_a;
  logic dv_p, pe_p, fe_p, bk_p, busy_p;
  logic dv_s, pe_s, fe_s, bk_s, busy_s;

  uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd), .dout(dout_a), .dout_vld(dv_a),
    .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a), .busy(busy_a));
  uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst), .rxd(rxd), .dout(dout_p), .dout_vld(dv_p),
    .parity_err(pe_p), .frame_err(fe_p), .break_det(bk_p), .busy(busy_p));
  uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .rxd(rxd), .dout(dout_s), .dout_vld(dv_s),
    .parity_err(pe_s), .frame_err(fe_s), .break_det(bk_s), .busy(busy_s));

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
    int         cyc;
  } pulse_t;

  typedef struct {
    int         sel;
    logic [8:0] data;
    logic       par;
    logic [1:0] stops;
    logic [8:0] ed;
    logic       epe;
    logic       efe;
    logic       ebrk;
  } vec_t;

  pulse_t q_a[$], q_p[$], q_s[$], exp_q[$];
  int n_tests = 0, n_fail = 0, qual_viol = 0;
  int start_cyc = 0, last_cyc = 0;
  vec_t tbl[12];

  // Capture every report; flags without dout_vld are a violation.
  always @(negedge clk) begin
    if (dv_a) q_a.push_back('{9'(dout_a), pe_a, fe_a, bk_a, cyc});
    else if (pe_a | fe_a | bk_a) qual_viol++;
    if (dv_p) q_p.push_back('{9'(dout_p), pe_p, fe_p, bk_p, cyc});
    else if (pe_p | fe_p | bk_p) qual_viol++;
    if (dv_s) q_s.push_back('{9'(dout_s), pe_s, fe_s, bk_s, cyc});
    else if (pe_s | fe_s | bk_s) qual_viol++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Frame-level rules: what the receiver must report for a frame as sent.
  function automatic pulse_t model(input int dbits, input logic [8:0] data, input int pmode,
                                   input logic par, input int nstop, input logic [1:0] stops);
    pulse_t r;
    logic [8:0] d;
    logic ep, last;
    d     = 9'(int'(data) & ((1 << dbits) - 1));
    ep    = (pmode == 2) ? ^d : ~^d;
    last  = stops[nstop-1];
    r.d   = d;
    r.pe  = (pmode != 0) && (par != ep);
    r.fe  = (nstop == 2) ? !(stops[0] && stops[1]) : !stops[0];
    r.brk = (d == 0) && (pmode == 0 || par == 1'b0) && !last;
    r.cyc = 0;
    return r;
  endfunction

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rxd = v;
    end
  endtask

  // per = bit period in hundredths of a clock; glitch inverts two cycles mid-bit.
  task automatic send_frame(input int dbits, input logic [8:0] data, input int pmode,
                            input logic par, input int nstop, input logic [1:0] stops,
                            input int per, input bit glitch, input int gap);
    logic bits[$];
    int t0, t1;
    bits.push_back(1'b0);
    for (int i = 0; i < dbits; i++) bits.push_back(data[i]);
    if (pmode != 0) bits.push_back(par);
    for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
    for (int b = 0; b < bits.size(); b++) begin
      t0 = b * per / 100;
      t1 = (b + 1) * per / 100;
      for (int c = 0; c < t1 - t0; c++) begin
        @(posedge clk); #1;
        rxd = (glitch && (c == 14 || c == 15)) ? ~bits[b] : bits[b];
        if (b == 0 && c == 0) start_cyc = cyc;
      end
    end
    drive(1'b1, gap);
  endtask

  task automatic phase_reset();
    @(posedge clk); #1;
    rxd = 1'b1;
    rst = 1'b1;
    drive(1'b1, 2);
    rst = 1'b0;
    drive(1'b1, 5);
    q_a.delete(); q_p.delete(); q_s.delete(); exp_q.delete();
  endtask

  // Compare everything captured on one receiver with exp_q, then clear both.
  task automatic expect_all(input int sel, input string nm);
    pulse_t got[$];
    case (sel)
      0:       got = q_a;
      1:       got = q_p;
      default: got = q_s;
    endcase
    check({nm, ".count"}, got.size(), exp_q.size());
    if (exp_q.size() == 0) $display("[TB] %s: no frame reported", nm);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s[%0d].dout", nm, i), got[i].d, exp_q[i].d);
      check($sformatf("%s[%0d].parity_err", nm, i), got[i].pe, exp_q[i].pe);
      check($sformatf("%s[%0d].frame_err", nm, i), got[i].fe, exp_q[i].fe);
      check($sformatf("%s[%0d].break_det", nm, i), got[i].brk, exp_q[i].brk);
      $display("[TB] %s[%0d]: dout=0x%0h pe=%0b fe=%0b brk=%0b", nm, i,
               got[i].d, got[i].pe, got[i].fe, got[i].brk);
      last_cyc = got[i].cyc;
    end
    exp_q.delete();
    case (sel)
      0:       q_a.delete();
      1:       q_p.delete();
      default: q_s.delete();
    endcase
  endtask

  initial begin
    int lat, per;
    logic [8:0] d;
    logic par, stp;
    pulse_t e;

    // sel, data, parity bit, stop bits {2nd,1st}, expected dout/pe/fe/brk
    tbl[0]  = '{1, 9'h07, 1'b0, 2'b01, 9'h07, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1, 9'h07, 1'b1, 2'b01, 9'h07, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1, 9'hFF, 1'b0, 2'b01, 9'hFF, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1, 9'h80, 1'b1, 2'b01, 9'h80, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1, 9'h80, 1'b1, 2'b00, 9'h80, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1, 9'h00, 1'b1, 2'b00, 9'h00, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1, 9'h00, 1'b0, 2'b00, 9'h00, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{2, 9'h55, 1'b1, 2'b11, 9'h55, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2, 9'h55, 1'b1, 2'b01, 9'h55, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{2, 9'h2A, 1'b0, 2'b10, 9'h2A, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{2, 9'h7F, 1'b1, 2'b11, 9'h7F, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{2, 9'h00, 1'b0, 2'b00, 9'h00, 1'b1, 1'b1, 1'b1};

    // Reset state
    drive(1'b1, 3);
    check("rst.dout", dout_a, 0);
    check("rst.dout_vld", dv_a, 0);
    check("rst.flags", {pe_a, fe_a, bk_a}, 0);
    check("rst.busy", busy_a, 0);
    rst = 1'b0;
    drive(1'b1, 5);

    // 0x55 with ideal timing, including report latency from the start edge
    phase_reset();
    send_frame(8, 9'h55, 0, 1'b0, 1, 2'b01, CD * 100, 1'b0, 40);
    exp_q.push_back(model(8, 9'h55, 0, 1'b0, 1, 2'b01));
    expect_all(0, "f55");
    lat = last_cyc - start_cyc;
    n_tests++;
    if (lat < 310 || lat > 316) begin
      n_fail++;
      $display("FAIL f55.latency: got %0d cycles, expected 313 +/- 3", lat);
    end

    // Short low pulse on an idle line is rejected
    drive(1'b0, 10);
    drive(1'b1, 60);
    expect_all(0, "short_pulse");
    check("short_pulse.busy", busy_a, 0);

    // 0xA3 with a two-cycle glitch in every bit
    send_frame(8, 9'hA3, 0, 1'b0, 1, 2'b01, CD * 100, 1'b1, 40);
    exp_q.push_back(model(8, 9'hA3, 0, 1'b0, 1, 2'b01));
    expect_all(0, "glitchy_a3");

    // Table of parity / framing / break frames
    for (int i = 0; i < 12; i++) begin
      phase_reset();
      if (tbl[i].sel == 1)
        send_frame(8, tbl[i].data, 2, tbl[i].par, 1, tbl[i].stops, CD * 100, 1'b0, 48);
      else
        send_frame(7, tbl[i].data, 1, tbl[i].par, 2, tbl[i].stops, CD * 100, 1'b0, 48);
      exp_q.push_back('{tbl[i].ed, tbl[i].epe, tbl[i].efe, tbl[i].ebrk, 0});
      expect_all(tbl[i].sel, $sformatf("vec%0d", i));
    end

    // Random 8E1 frames with occasional bad parity or stop bits
    phase_reset();
    for (int i = 0; i < 16; i++) begin
      d   = 9'($urandom_range(0, 255));
      par = (^d[7:0]) ^ ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(8, d, 2, par, 1, {1'b1, stp}, CD * 100, 1'b0, 48);
      exp_q.push_back(model(8, d, 2, par, 1, {1'b1, stp}));
      expect_all(1, $sformatf("rnd_p%0d", i));
    end

    // Random 8N1 frames at -2 %, 0 %, +2 % period error
    phase_reset();
    for (int i = 0; i < 16; i++) begin
      d   = 9'($urandom_range(0, 255));
      per = (int'($urandom_range(0, 2)) - 1) * 64 + CD * 100;
      send_frame(8, d, 0, 1'b0, 1, 2'b01, per, 1'b0, 40);
      exp_q.push_back(model(8, d, 0, 1'b0, 1, 2'b01));
      expect_all(0, $sformatf("rnd_a%0d", i));
    end

    // Back-to-back frames, no idle gap, at +2 % and -2 % period error
    for (int r = 0; r < 2; r++) begin
      phase_reset();
      per = (r == 0) ? 3264 : 3136;
      for (int i = 0; i < 4; i++) begin
        d = 9'($urandom_range(0, 255));
        send_frame(8, d, 0, 1'b0, 1, 2'b01, per, 1'b0, 0);
        exp_q.push_back(model(8, d, 0, 1'b0, 1, 2'b01));
      end
      drive(1'b1, 60);
      expect_all(0, $sformatf("b2b%0d", r));
    end

    // Break: line low for 20 bit times, then short high, then long high
    phase_reset();
    drive(1'b0, 20 * CD);
    exp_q.push_back('{9'h000, 1'b0, 1'b1, 1'b1, 0});
    expect_all(0, "break");
    drive(1'b1, 10);
    drive(1'b0, 40);
    expect_all(0, "break_hold");
    check("break_hold.busy", busy_a, 1);
    drive(1'b1, 40);
    check("break_done.busy", busy_a, 0);
    send_frame(8, 9'h3C, 0, 1'b0, 1, 2'b01, CD * 100, 1'b0, 40);
    exp_q.push_back(model(8, 9'h3C, 0, 1'b0, 1, 2'b01));
    expect_all(0, "after_break");

    // Reset during data bit 4 discards the frame
    drive(1'b0, CD);
    drive(1'b0, CD);
    drive(1'b1, CD);
    drive(1'b0, CD);
    drive(1'b1, CD);
    drive(1'b1, CD / 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst.busy", busy_a, 0);
    check("mid_rst.dout", dout_a, 0);
    #1 rxd = 1'b1;
    drive(1'b1, 2);
    rst = 1'b0;
    drive(1'b1, 100);
    expect_all(0, "mid_rst");
    send_frame(8, 9'hC6, 0, 1'b0, 1, 2'b01, CD * 100, 1'b0, 40);
    exp_q.push_back(model(8, 9'hC6, 0, 1'b0, 1, 2'b01));
    expect_all(0, "after_rst");

    check("flags_qualified", qual_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
